// File: rtl/systolic_psum_column_accumulator.sv
// Accumulates two-lane partial sums from one systolic PE column across Tin chunks,
// one accumulator pair per pixel slot, and queues finished pairs in a small output FIFO.
module systolic_psum_column_accumulator #(
  parameter int PSUM_W     = 20,
  parameter int ACC_W      = 32,
  parameter int DEPTH      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [$clog2(DEPTH+1)-1:0]   cfg_len,
  input  logic                         psum_vld,
  input  logic                         psum_first,
  input  logic                         psum_last,
  input  logic [2*PSUM_W-1:0]          psum_dat,
  output logic [2*ACC_W-1:0]           acc_dat,
  output logic                         acc_vld,
  input  logic                         acc_rdy,
  output logic                         ovf,
  output logic                         busy
);

  localparam int LEN_W   = $clog2(DEPTH+1);
  localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int FIFO_AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W   = $clog2(FIFO_DEPTH+1);

  // Output handshake: acc_dat is transferred on every cycle where acc_vld && acc_rdy;
  // acc_dat holds steady while acc_vld is high and acc_rdy is low.

  logic [LEN_W-1:0]        ptr;
  logic [LEN_W-1:0]        len_q;
  logic [LEN_W-1:0]        cfg_eff;
  logic [LEN_W-1:0]        len_cur;
  logic                    ptr_wrap;
  logic [PTR_W-1:0]        slot;

  logic signed [ACC_W-1:0] acc0 [DEPTH];
  logic signed [ACC_W-1:0] acc1 [DEPTH];
  logic signed [PSUM_W-1:0] p0, p1;
  logic signed [ACC_W-1:0] s0, s1;
  logic signed [ACC_W-1:0] new0, new1;

  logic [2*ACC_W-1:0]      mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]        count;
  logic                    pop, push_req, push;

  // A zero length would never wrap, so it behaves as a one-pixel pass.
  assign cfg_eff  = (cfg_len == '0) ? LEN_W'(1) : cfg_len;
  assign len_cur  = (ptr == '0) ? cfg_eff : len_q;
  assign ptr_wrap = (ptr == (len_cur - LEN_W'(1)));
  assign slot     = ptr[PTR_W-1:0];

  assign p0   = psum_dat[PSUM_W-1:0];
  assign p1   = psum_dat[2*PSUM_W-1:PSUM_W];
  assign s0   = ACC_W'(p0);
  assign s1   = ACC_W'(p1);
  assign new0 = psum_first ? s0 : acc0[slot] + s0;
  assign new1 = psum_first ? s1 : acc1[slot] + s1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr   <= '0;
      len_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        acc0[i] <= '0;
        acc1[i] <= '0;
      end
    end else if (psum_vld) begin
      if (ptr == '0) len_q <= cfg_eff;
      ptr        <= ptr_wrap ? '0 : ptr + LEN_W'(1);
      acc0[slot] <= new0;
      acc1[slot] <= new1;
    end
  end

  // A full FIFO still accepts a result when its head leaves in the same cycle.
  assign pop      = acc_vld && acc_rdy;
  assign push_req = psum_vld && psum_last;
  assign push     = push_req && ((count != CNT_W'(FIFO_DEPTH)) || pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
      if (push_req && !push) ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {new1, new0};
  end

  assign acc_vld = (count != '0);
  assign acc_dat = acc_vld ? mem[rd_ptr] : '0;
  assign busy    = (ptr != '0);

endmodule

// File: tb/tb_systolic_psum_column_accumulator.sv
// Directed bench for systolic_psum_column_accumulator: a per-cycle vector table for
// the basic passes plus scripted sequences for gaps, backpressure, overflow and reset.
module tb_systolic_psum_column_accumulator;

  localparam int PSUM_W = 20;
  localparam int ACC_W  = 32;
  localparam int DEPTH  = 16;
  localparam int FDEP   = 4;
  localparam int LEN_W  = $clog2(DEPTH+1);

  logic                clk;
  logic                rst_n;
  logic [LEN_W-1:0]    cfg_len;
  logic                psum_vld, psum_first, psum_last;
  logic [2*PSUM_W-1:0] psum_dat;
  logic [2*ACC_W-1:0]  acc_dat;
  logic                acc_vld, acc_rdy, ovf, busy;

  systolic_psum_column_accumulator #(
    .PSUM_W(PSUM_W), .ACC_W(ACC_W), .DEPTH(DEPTH), .FIFO_DEPTH(FDEP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_len(cfg_len),
    .psum_vld(psum_vld), .psum_first(psum_first), .psum_last(psum_last),
    .psum_dat(psum_dat), .acc_dat(acc_dat), .acc_vld(acc_vld),
    .acc_rdy(acc_rdy), .ovf(ovf), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic             vld;
    logic             first;
    logic             last;
    logic [LEN_W-1:0] cfg;
    int               l0;
    int               l1;
    logic             exp_vld;
    int               e0;
    int               e1;
    logic             exp_busy;
  } vec_t;

  vec_t tbl[13];
  logic [2*ACC_W-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;
  int pops  = 0;
  logic mon_en = 1'b0;

  function automatic logic [2*ACC_W-1:0] mk(input int a0, input int a1);
    return {a1, a0};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs are stable here (posedge+1); a head that is valid and ready leaves at the next edge.
  task automatic cycle();
    if (mon_en && acc_vld && acc_rdy) begin
      pops++;
      if (exp_q.size() == 0) chk("unexpected_pop", acc_dat, 64'hx);
      else chk("pop_dat", acc_dat, exp_q.pop_front());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input logic f, input logic l, input int a0, input int a1);
    psum_vld   = 1'b1;
    psum_first = f;
    psum_last  = l;
    psum_dat   = {a1[PSUM_W-1:0], a0[PSUM_W-1:0]};
  endtask

  task automatic send(input logic f, input logic l, input int a0, input int a1, input int gap_max);
    set_beat(f, l, a0, a1);
    cycle();
    psum_vld = 1'b0;
    psum_first = 1'b0;
    psum_last = 1'b0;
    repeat ($urandom_range(0, gap_max)) cycle();
  endtask

  task automatic do_reset();
    psum_vld = 1'b0; psum_first = 1'b0; psum_last = 1'b0; psum_dat = '0;
    acc_rdy = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
  endtask

  task automatic drain(input int cycles);
    acc_rdy = 1'b1;
    pops = 0;
    repeat (cycles) cycle();
  endtask

  initial begin
    tbl[0]  = '{1'b1, 1'b1, 1'b1, 5'd2, 5, -3,       1'b1, 5, -3,       1'b1};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 5'd2, -7, 100,     1'b1, -7, 100,     1'b0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 5'd2, 0, 0,        1'b0, 0, 0,        1'b0};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 5'd3, 1, -1,       1'b0, 0, 0,        1'b1};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 5'd3, 2, -2,       1'b0, 0, 0,        1'b1};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 5'd3, 3, -3,       1'b0, 0, 0,        1'b0};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 5'd3, 10, -10,     1'b0, 0, 0,        1'b1};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 5'd3, 20, -20,     1'b0, 0, 0,        1'b1};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 5'd3, 30, -30,     1'b0, 0, 0,        1'b0};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 5'd3, 100, -100,   1'b1, 111, -111,   1'b1};
    tbl[10] = '{1'b1, 1'b0, 1'b1, 5'd3, 200, -200,   1'b1, 222, -222,   1'b1};
    tbl[11] = '{1'b1, 1'b0, 1'b1, 5'd3, 300, -300,   1'b1, 333, -333,   1'b0};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 5'd3, 0, 0,        1'b0, 0, 0,        1'b0};

    cfg_len = '0;
    do_reset();
    chk("rst_vld",  acc_vld, 1'b0);
    chk("rst_dat",  acc_dat, '0);
    chk("rst_ovf",  ovf, 1'b0);
    chk("rst_busy", busy, 1'b0);

    // single-chunk and three-chunk passes, one output consumed per cycle
    acc_rdy = 1'b1;
    for (int i = 0; i < 13; i++) begin
      cfg_len = tbl[i].cfg;
      if (tbl[i].vld) set_beat(tbl[i].first, tbl[i].last, tbl[i].l0, tbl[i].l1);
      else begin
        psum_vld = 1'b0; psum_first = 1'b0; psum_last = 1'b0; psum_dat = '0;
      end
      cycle();
      chk($sformatf("tbl%0d_vld", i), acc_vld, tbl[i].exp_vld);
      if (tbl[i].exp_vld) chk($sformatf("tbl%0d_dat", i), acc_dat, mk(tbl[i].e0, tbl[i].e1));
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].exp_busy);
    end
    psum_vld = 1'b0;

    // gaps between beats; a mid-chunk length change must be ignored
    mon_en = 1'b1;
    pops = 0;
    acc_rdy = 1'b1;
    cfg_len = 5'd3;
    for (int c = 0; c < 3; c++) begin
      for (int p = 0; p < 3; p++) begin
        int mul;
        mul = (c == 0) ? 1 : (c == 1) ? 10 : 100;
        if (p == 1) cfg_len = 5'd1;
        if (c == 2) exp_q.push_back(mk(111 * (p + 1), -111 * (p + 1)));
        send(c == 0, c == 2, (p + 1) * mul, -(p + 1) * mul, 2);
        if (p == 2) cfg_len = 5'd3;
      end
    end
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) cycle();
    chk("gap_pops", pops, 3);
    chk("gap_busy", busy, 1'b0);

    // backpressure: four results kept, fifth dropped
    do_reset();
    cfg_len = 5'd1;
    for (int k = 1; k <= 5; k++) begin
      if (k <= 4) exp_q.push_back(mk(k, -k));
      send(1'b1, 1'b1, k, -k, 0);
      if (k == 4) chk("bp_ovf_before", ovf, 1'b0);
    end
    chk("bp_ovf", ovf, 1'b1);
    chk("bp_vld", acc_vld, 1'b1);
    chk("bp_head", acc_dat, mk(1, -1));
    drain(10);
    chk("bp_pops", pops, 4);
    chk("bp_empty", acc_vld, 1'b0);

    // full FIFO accepts a result when a pop happens in the same cycle
    do_reset();
    cfg_len = 5'd1;
    for (int k = 11; k <= 14; k++) begin
      exp_q.push_back(mk(k, -k));
      send(1'b1, 1'b1, k, -k, 0);
    end
    exp_q.push_back(mk(15, -15));
    acc_rdy = 1'b1;
    send(1'b1, 1'b1, 15, -15, 0);
    acc_rdy = 1'b0;
    chk("full_ovf", ovf, 1'b0);
    chk("full_vld", acc_vld, 1'b1);
    chk("full_head", acc_dat, mk(12, -12));
    drain(10);
    chk("full_pops", pops, 4);
    chk("full_ovf_end", ovf, 1'b0);

    // async reset mid-pass with two entries queued and ovf set
    do_reset();
    cfg_len = 5'd1;
    for (int k = 1; k <= 5; k++) send(1'b1, 1'b1, k, -k, 0);
    exp_q.push_back(mk(1, -1));
    exp_q.push_back(mk(2, -2));
    acc_rdy = 1'b1;
    cycle();
    cycle();
    acc_rdy = 1'b0;
    cfg_len = 5'd3;
    send(1'b1, 1'b0, 9, 9, 0);
    chk("pre_rst_busy", busy, 1'b1);
    chk("pre_rst_vld", acc_vld, 1'b1);
    chk("pre_rst_ovf", ovf, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_vld", acc_vld, 1'b0);
    chk("arst_ovf", ovf, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_dat", acc_dat, '0);
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
    pops = 0;
    acc_rdy = 1'b1;
    cfg_len = 5'd2;
    send(1'b1, 1'b0, 7, -8, 1);
    send(1'b1, 1'b0, 9, 1, 1);
    exp_q.push_back(mk(8, -7));
    send(1'b0, 1'b1, 1, 1, 1);
    exp_q.push_back(mk(11, -1));
    send(1'b0, 1'b1, 2, -2, 1);
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) cycle();
    chk("post_rst_pops", pops, 2);
    chk("post_rst_ovf", ovf, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
